// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared state encoding and PC width for the fetch sequencer
package pc_fetch_ctrl_pkg;
    localparam int PC_W = 16;
    typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_e;
endpackage

// File: rtl/pc_fetch_ctrl_inc16.sv
// inc16: 16-bit incrementer, wraps 16'hFFFF to 16'h0000
module inc16 (
    output logic [15:0] out,
    input  logic [15:0] in
);
    assign out = in + 16'd1;
endmodule

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: PC sequencer with req/ack instruction fetch and valid/ready delivery
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_VECTOR = 16'h0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    input  logic            jump_valid,
    input  logic [PC_W-1:0] jump_addr,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [PC_W-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] instr_pc,
    input  logic            instr_ready
);
    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, pc_inc;
    logic [PC_W-1:0]   jump_tgt_q, jump_tgt_d;
    logic [PC_W-1:0]   instr_q, instr_d, instr_pc_q, instr_pc_d;
    logic              jump_pend_q, jump_pend_d;
    logic              instr_valid_q, instr_valid_d;
    logic              imem_req_q, imem_req_d;

    inc16 u_inc (.out(pc_inc), .in(pc_q));

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        jump_pend_d   = jump_pend_q;
        jump_tgt_d    = jump_tgt_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        case (state_q)
            IDLE: begin
                if (jump_valid) pc_d = jump_addr;
                if (run) state_d = FETCH;
            end
            FETCH: begin
                if (imem_ack) begin
                    // a jump seen before or with the ack turns the returned word into a discard
                    if (jump_pend_q || jump_valid) begin
                        pc_d        = jump_valid ? jump_addr : jump_tgt_q;
                        jump_pend_d = 1'b0;
                    end else begin
                        instr_d       = imem_rdata;
                        instr_pc_d    = pc_q;
                        instr_valid_d = 1'b1;
                        state_d       = HOLD;
                    end
                end else if (jump_valid) begin
                    jump_pend_d = 1'b1;
                    jump_tgt_d  = jump_addr;
                end
            end
            HOLD: begin
                if (jump_valid || instr_ready) begin
                    pc_d          = jump_valid ? jump_addr : pc_inc;
                    instr_valid_d = 1'b0;
                    state_d       = run ? FETCH : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        imem_req_d = (state_d == FETCH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            jump_pend_q   <= 1'b0;
            jump_tgt_q    <= '0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            jump_pend_q   <= jump_pend_d;
            jump_tgt_q    <= jump_tgt_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed and random checks of pc_fetch_ctrl against a behavioural model
module tb_pc_fetch_ctrl;
    localparam logic [15:0] RV = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        jump_valid = 1'b0;
    logic [15:0] jump_addr = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_ready = 1'b0;

    pc_fetch_ctrl #(.RESET_VECTOR(RV)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int wcnt = 0;
    int lat = 2;
    bit rand_lat = 1'b0;
    logic [15:0] cons_pc[$];
    logic [15:0] cons_word[$];

    // model: is a request outstanding, is a word waiting downstream, where will the next fetch go
    bit          m_fetching, m_holding, m_pend;
    logic [15:0] m_pc, m_tgt, m_instr, m_ipc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_fetching = 0; m_holding = 0; m_pend = 0;
        m_pc = RV; m_tgt = '0; m_instr = '0; m_ipc = '0;
        wcnt = 0;
    endtask

    task automatic tick();
        bit          n_fetching, n_holding, n_pend;
        logic [15:0] n_pc, n_tgt, n_instr, n_ipc;
        imem_ack   = imem_req ? (wcnt >= lat) : (rand_lat && $urandom_range(0, 4) == 0);
        imem_rdata = imem_ack && imem_req ? (imem_addr ^ 16'hA5A5) : 16'($urandom);
        if (rst_n && instr_valid && instr_ready) begin
            cons_pc.push_back(instr_pc);
            cons_word.push_back(instr);
            chk("consumed_word", instr, instr_pc ^ 16'hA5A5);
        end
        n_fetching = m_fetching; n_holding = m_holding; n_pend = m_pend;
        n_pc = m_pc; n_tgt = m_tgt; n_instr = m_instr; n_ipc = m_ipc;
        if (m_holding) begin
            if (jump_valid || instr_ready) begin
                n_holding  = 0;
                n_pc       = jump_valid ? jump_addr : m_pc + 16'd1;
                n_fetching = run;
            end
        end else if (m_fetching) begin
            if (imem_ack && (m_pend || jump_valid)) begin
                n_pc   = jump_valid ? jump_addr : m_tgt;
                n_pend = 0;
            end else if (imem_ack) begin
                n_instr = imem_rdata; n_ipc = m_pc; n_holding = 1; n_fetching = 0;
            end else if (jump_valid) begin
                n_pend = 1; n_tgt = jump_addr;
            end
        end else begin
            if (jump_valid) n_pc = jump_addr;
            if (run) n_fetching = 1;
        end
        if (imem_req && imem_ack) begin
            wcnt = 0;
            if (rand_lat) lat = $urandom_range(0, 3);
        end else wcnt = imem_req ? wcnt + 1 : 0;
        @(posedge clk);
        #1;
        if (!rst_n) m_reset();
        else begin
            m_fetching = n_fetching; m_holding = n_holding; m_pend = n_pend;
            m_pc = n_pc; m_tgt = n_tgt; m_instr = n_instr; m_ipc = n_ipc;
        end
        jump_valid = 1'b0;
        imem_ack   = 1'b0;
        chk("imem_req", imem_req, m_fetching);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", instr_valid, m_holding);
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
    endtask

    task automatic drain_to_idle(input string tag);
        for (int i = 0; i < 40 && (imem_req || instr_valid); i++) tick();
        chk(tag, {imem_req, instr_valid}, 2'b00);
    endtask

    initial begin
        int n;
        logic [15:0] s_i, s_p;
        m_reset();
        // boot
        instr_ready = 1'b1;
        #3;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_addr", imem_addr, RV);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", {instr, instr_pc}, 32'h0);
        repeat (2) tick();
        run = 1'b1;
        tick();
        chk("rst_req_run", imem_req, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 60 && cons_pc.size() < 3; i++) tick();
        chk("boot_cnt", cons_pc.size() >= 3, 1'b1);
        chk("boot_i0", {cons_pc[0], cons_word[0]}, {16'h0000, 16'hA5A5});
        chk("boot_i1", {cons_pc[1], cons_word[1]}, {16'h0001, 16'hA5A4});
        chk("boot_i2", {cons_pc[2], cons_word[2]}, {16'h0002, 16'hA5A7});
        // wrap
        run = 1'b0;
        drain_to_idle("wrap_idle");
        jump_valid = 1'b1; jump_addr = 16'hFFFF;
        tick();
        chk("wrap_jump_idle", imem_addr, 16'hFFFF);
        run = 1'b1;
        n = cons_pc.size();
        for (int i = 0; i < 30 && cons_pc.size() == n; i++) tick();
        chk("wrap_ipc", cons_pc[$], 16'hFFFF);
        for (int i = 0; i < 10 && !imem_req; i++) tick();
        chk("wrap_next_addr", imem_addr, 16'h0000);
        // backpressure
        instr_ready = 1'b0;
        for (int i = 0; i < 30 && !instr_valid; i++) tick();
        s_i = instr; s_p = instr_pc;
        repeat (5) begin
            tick();
            chk("bp_hold", {instr_valid, imem_req, instr, instr_pc, imem_addr}, {1'b1, 1'b0, s_i, s_p, s_p});
        end
        instr_ready = 1'b1;
        tick();
        for (int i = 0; i < 10 && !imem_req; i++) tick();
        chk("bp_next_addr", imem_addr, s_p + 16'd1);
        // jump while a fetch is outstanding
        run = 1'b0;
        drain_to_idle("jp_idle");
        jump_valid = 1'b1; jump_addr = 16'h0010;
        tick();
        lat = 4;
        run = 1'b1;
        tick();
        chk("jp_req", {imem_req, imem_addr}, {1'b1, 16'h0010});
        repeat (2) tick();
        jump_valid = 1'b1; jump_addr = 16'h0200;
        repeat (3) tick();
        chk("jp_redirect", {imem_req, imem_addr, instr_valid}, {1'b1, 16'h0200, 1'b0});
        n = cons_pc.size();
        for (int i = 0; i < 30 && cons_pc.size() == n; i++) tick();
        chk("jp_ipc", cons_pc[$], 16'h0200);
        // jump and ready together in HOLD
        lat = 1;
        run = 1'b0;
        drain_to_idle("jr_idle");
        instr_ready = 1'b0;
        jump_valid = 1'b1; jump_addr = 16'h0371;
        tick();
        run = 1'b1;
        for (int i = 0; i < 30 && !instr_valid; i++) tick();
        chk("jr_ipc", instr_pc, 16'h0371);
        jump_valid = 1'b1; jump_addr = 16'h1A68; instr_ready = 1'b1;
        tick();
        chk("jr_after", {instr_valid, imem_req, imem_addr}, {1'b0, 1'b1, 16'h1A68});
        // run=0 in HOLD, then asynchronous reset mid-fetch
        instr_ready = 1'b0;
        for (int i = 0; i < 30 && !instr_valid; i++) tick();
        run = 1'b0;
        repeat (2) tick();
        chk("stop_held", instr_valid, 1'b1);
        instr_ready = 1'b1;
        tick();
        chk("stop_idle", {instr_valid, imem_req}, 2'b00);
        repeat (2) tick();
        chk("stop_stay", imem_req, 1'b0);
        lat = 5;
        run = 1'b1;
        repeat (2) tick();
        chk("ar_midfetch", imem_req, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("ar_req", imem_req, 1'b0);
        chk("ar_addr", imem_addr, RV);
        chk("ar_valid", instr_valid, 1'b0);
        m_reset();
        #1;
        rst_n = 1'b1;
        // random traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            run         = ($urandom_range(0, 7) != 0);
            jump_valid  = ($urandom_range(0, 9) == 0);
            jump_addr   = 16'($urandom);
            instr_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
